// File: rtl/forwarding_hazard_ctrl_if.sv
// Hazard-unit handshake: ID-stage operand/destination info in, forwarding and
// stall/flush controls plus event counters out.
interface forwarding_hazard_ctrl_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic [REG_ADDR_W-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  ex_flush;
    logic [1:0]            fwd_a;
    logic [1:0]            fwd_b;
    logic                  stall;
    logic                  flush_id;
    logic [CNT_W-1:0]      stall_count;
    logic [CNT_W-1:0]      flush_count;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_flush,
        input  fwd_a, fwd_b, stall, flush_id, stall_count, flush_count
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, ex_flush,
        output fwd_a, fwd_b, stall, flush_id, stall_count, flush_count
    );
endinterface

// File: rtl/forwarding_hazard_ctrl.sv
// Forwarding / load-use hazard controller for a 5-stage pipeline: tracks the
// EX, MEM and WB pipeline registers and derives mux selects, stall and flush.
module forwarding_hazard_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
) (
    input logic                     CLK,
    input logic                     RESET,
    forwarding_hazard_ctrl_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [REG_ADDR_W-1:0] rs1;
        logic [REG_ADDR_W-1:0] rs2;
        logic                  regwrite;
        logic                  memread;
    } slot_t;

    localparam logic [1:0]       FWD_RF  = 2'b00;
    localparam logic [1:0]       FWD_MEM = 2'b01;
    localparam logic [1:0]       FWD_WB  = 2'b10;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    slot_t            ex_q, ex_d;
    slot_t            mem_q, mem_d;
    slot_t            wb_q, wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             stall_raw;
    slot_t            id_slot;

    // A load in MEM has no data yet, so it falls through to the WB check.
    function automatic logic [1:0] fwd_sel(input logic [REG_ADDR_W-1:0] src,
                                           input slot_t ex, input slot_t mem,
                                           input slot_t wb);
        logic [1:0] sel;
        sel = FWD_RF;
        if (ex.valid) begin
            if (mem.valid && mem.regwrite && !mem.memread &&
                (mem.rd != '0) && (mem.rd == src))
                sel = FWD_MEM;
            else if (wb.valid && wb.regwrite && (wb.rd != '0) && (wb.rd == src))
                sel = FWD_WB;
        end
        return sel;
    endfunction

    always_comb begin
        stall_raw = ex_q.valid && ex_q.memread && (ex_q.rd != '0) && bus.id_valid &&
                    ((bus.id_rs1 == ex_q.rd) || (bus.id_rs2 == ex_q.rd)) &&
                    !bus.ex_flush;

        id_slot          = '0;
        id_slot.valid    = bus.id_valid;
        id_slot.rd       = bus.id_rd;
        id_slot.rs1      = bus.id_rs1;
        id_slot.rs2      = bus.id_rs2;
        id_slot.regwrite = bus.id_regwrite;
        id_slot.memread  = bus.id_memread;

        // Older instructions always advance; only the ID entry can be replaced.
        wb_d  = mem_q;
        mem_d = ex_q;
        ex_d  = (stall_raw || bus.ex_flush) ? slot_t'('0) : id_slot;

        stall_cnt_d = stall_cnt_q;
        if (stall_raw && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_ONE;

        flush_cnt_d = flush_cnt_q;
        if (bus.ex_flush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_ONE;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Controls are forced quiet while reset is held, whatever the slots contain.
    assign bus.stall       = stall_raw && !RESET;
    assign bus.flush_id    = bus.ex_flush && !RESET;
    assign bus.fwd_a       = RESET ? FWD_RF : fwd_sel(ex_q.rs1, ex_q, mem_q, wb_q);
    assign bus.fwd_b       = RESET ? FWD_RF : fwd_sel(ex_q.rs2, ex_q, mem_q, wb_q);
    assign bus.stall_count = stall_cnt_q;
    assign bus.flush_count = flush_cnt_q;

endmodule

// File: tb/tb_forwarding_hazard_ctrl.sv
// Randomized + directed bench for forwarding_hazard_ctrl with a queue-based
// pipeline model and a scoreboard checked by an independent monitor.
module tb_forwarding_hazard_ctrl;
    localparam int RW   = 5;
    localparam int CW   = 8;
    localparam int CMAX = (1 << CW) - 1;

    typedef struct {
        bit v;
        int rd;
        int rs1;
        int rs2;
        bit rw;
        bit mr;
    } ins_t;

    typedef struct {
        int fa;
        int fb;
        bit st;
        bit fl;
        int sc;
        int fc;
    } exp_t;

    logic CLK = 1'b0;
    logic RESET;
    always #5 CLK = ~CLK;

    forwarding_hazard_ctrl_if #(.REG_ADDR_W(RW), .CNT_W(CW)) ifc ();

    forwarding_hazard_ctrl #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (ifc)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    ins_t hist[$];   // hist[0] = instruction in EX, [1] = MEM, [2] = WB
    int   sc_m, fc_m;

    function automatic ins_t mk(bit v, int rd, int rs1, int rs2, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rd = rd; i.rs1 = rs1; i.rs2 = rs2; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic ins_t bubble();
        return mk(0, 0, 0, 0, 0, 0);
    endfunction

    // Youngest older producer wins; a load still in MEM cannot supply data yet.
    function automatic int fwd_of(int src);
        if (!hist[0].v) return 0;
        for (int age = 1; age <= 2; age++) begin
            ins_t p = hist[age];
            if (p.v && p.rw && p.rd != 0 && p.rd == src && !(age == 1 && p.mr))
                return age;
        end
        return 0;
    endfunction

    task automatic model_reset();
        hist = {};
        for (int k = 0; k < 3; k++) hist.push_back(bubble());
        sc_m = 0;
        fc_m = 0;
    endtask

    task automatic cycle(input bit r, input bit fl, input ins_t i, output bit st);
        exp_t e;
        ins_t ex;
        @(posedge CLK);
        #1;
        RESET           = r;
        ifc.id_valid    = i.v;
        ifc.id_rd       = RW'(i.rd);
        ifc.id_rs1      = RW'(i.rs1);
        ifc.id_rs2      = RW'(i.rs2);
        ifc.id_regwrite = i.rw;
        ifc.id_memread  = i.mr;
        ifc.ex_flush    = fl;
        ex = hist[0];
        st = !r && !fl && ex.v && ex.mr && ex.rd != 0 && i.v &&
             (i.rs1 == ex.rd || i.rs2 == ex.rd);
        e.fa = r ? 0 : fwd_of(ex.rs1);
        e.fb = r ? 0 : fwd_of(ex.rs2);
        e.st = st;
        e.fl = fl && !r;
        e.sc = sc_m;
        e.fc = fc_m;
        expq.push_back(e);
        if (r) begin
            model_reset();
        end else begin
            if (st && sc_m < CMAX) sc_m++;
            if (fl && fc_m < CMAX) fc_m++;
            hist.push_front((st || fl) ? bubble() : (i.v ? i : bubble()));
            void'(hist.pop_back());
        end
    endtask

    // Pipeline holds IF/ID on a stall, so the same instruction is re-presented.
    task automatic issue(input ins_t i, input bit fl = 0);
        bit st;
        int n = 0;
        do begin
            cycle(0, fl, i, st);
            n++;
        end while (st && n < 4);
    endtask

    task automatic nop();
        issue(mk(1, 0, 0, 0, 0, 0));
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge CLK);
            if (expq.size() > 0) begin
                e = expq.pop_front();
                checks++;
                if (ifc.fwd_a !== 2'(e.fa) || ifc.fwd_b !== 2'(e.fb) ||
                    ifc.stall !== e.st || ifc.flush_id !== e.fl ||
                    ifc.stall_count !== CW'(e.sc) || ifc.flush_count !== CW'(e.fc)) begin
                    errors++;
                    $display("FAIL outputs t=%0t got fa=%0d fb=%0d st=%0b fl=%0b sc=%0d fc=%0d want fa=%0d fb=%0d st=%0b fl=%0b sc=%0d fc=%0d",
                             $time, ifc.fwd_a, ifc.fwd_b, ifc.stall, ifc.flush_id,
                             ifc.stall_count, ifc.flush_count,
                             e.fa, e.fb, e.st, e.fl, e.sc, e.fc);
                end
            end
        end
    end

    initial begin : driver
        bit st;
        RESET = 1'b1;
        ifc.id_valid = 0; ifc.id_rd = '0; ifc.id_rs1 = '0; ifc.id_rs2 = '0;
        ifc.id_regwrite = 0; ifc.id_memread = 0; ifc.ex_flush = 0;
        model_reset();
        repeat (2) @(posedge CLK);
        cycle(1, 0, bubble(), st);
        cycle(1, 1, mk(1, 3, 3, 3, 1, 1), st);

        // Back-to-back ALU dependence: MEM forward on rs1
        issue(mk(1, 5, 1, 2, 1, 0));
        issue(mk(1, 6, 5, 1, 1, 0));
        nop(); nop(); nop();

        // One instruction gap: WB forward on rs2
        issue(mk(1, 5, 1, 2, 1, 0));
        nop();
        issue(mk(1, 7, 1, 5, 1, 0));
        nop(); nop();

        // x5 written in both MEM and WB: MEM copy wins
        issue(mk(1, 5, 1, 2, 1, 0));
        issue(mk(1, 5, 3, 4, 1, 0));
        issue(mk(1, 7, 5, 5, 1, 0));
        nop(); nop(); nop();

        // Load-use: one stall then WB forward on both operands
        issue(mk(1, 8, 1, 0, 1, 1));
        issue(mk(1, 9, 8, 8, 1, 0));
        nop(); nop(); nop();

        // Load-use coinciding with a taken branch: flush wins
        issue(mk(1, 8, 1, 0, 1, 1));
        issue(mk(1, 9, 8, 8, 1, 0), 1);
        nop(); nop(); nop();

        // x0 never forwards or stalls
        issue(mk(1, 0, 1, 2, 1, 0));
        issue(mk(1, 1, 0, 0, 1, 0));
        issue(mk(1, 0, 1, 2, 1, 1));
        issue(mk(1, 2, 0, 0, 1, 0));
        nop(); nop(); nop();

        // Drive both counters into saturation
        for (int k = 0; k < CMAX + 5; k++) issue(mk(1, 8, 8, 0, 1, 1));
        for (int k = 0; k < CMAX + 5; k++) issue(mk(1, 1, 2, 3, 1, 0), 1);
        nop(); nop(); nop();

        // Reset while a load-use stall is pending
        issue(mk(1, 8, 1, 0, 1, 1));
        cycle(1, 0, mk(1, 9, 8, 8, 1, 0), st);
        nop(); nop();

        for (int k = 0; k < 3000; k++) begin
            ins_t ri;
            bit rst_r, fl_r;
            ri = mk($urandom_range(99) < 85, $urandom_range(7), $urandom_range(7),
                    $urandom_range(7), $urandom_range(99) < 75, $urandom_range(99) < 30);
            fl_r  = $urandom_range(99) < 10;
            rst_r = $urandom_range(999) < 15;
            if (rst_r) cycle(1, fl_r, ri, st);
            else issue(ri, fl_r);
        end

        @(negedge CLK);
        #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d pending want 0", expq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
